id_stage: RTL and testbench

- Instruction decode stage of the RISC-V core.
- Sits directly upstream of the register file: drives the rs1/rs2 read addresses, consumes r_data1/r_data2, and generates the immediate.
- Captures the decoded instruction into an ID/EX pipeline register with a valid/ready handshake.
- Detects load-use hazards, handles flush, and optionally bypasses same-cycle writeback data.

---
 rtl/id_stage_if.sv | 43 ++++
 rtl/id_stage.sv | 132 +++++++++++++
 tb/tb_id_stage.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// Fetch-side, register-file and ID/EX signals of the decode stage.
interface id_stage_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] r_data1;
    logic [XLEN-1:0] r_data2;
    logic            wb_w_enb;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_w_data;
    logic            ex_flush;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_op_a;
    logic [XLEN-1:0] ex_op_b;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rd;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic            ex_funct7b5;
    logic            ex_is_load;
    logic            ex_illegal;

    modport slave (
        input  if_valid, if_instr, if_pc, r_data1, r_data2,
               wb_w_enb, wb_rd, wb_w_data, ex_flush, ex_ready,
        output if_ready, rs1, rs2, ex_valid, ex_pc, ex_op_a, ex_op_b, ex_imm,
               ex_rd, ex_opcode, ex_funct3, ex_funct7b5, ex_is_load, ex_illegal
    );

    modport master (
        output if_valid, if_instr, if_pc, r_data1, r_data2,
               wb_w_enb, wb_rd, wb_w_data, ex_flush, ex_ready,
        input  if_ready, rs1, rs2, ex_valid, ex_pc, ex_op_a, ex_op_b, ex_imm,
               ex_rd, ex_opcode, ex_funct3, ex_funct7b5, ex_is_load, ex_illegal
    );
endinterface

// File: rtl/id_stage.sv
// RV32I decode into a one-entry ID/EX register; one-cycle latency, if_ready drops on EX stall or load-use hazard.
// Define ID_WB_BYPASS_EN to forward a same-cycle register-file write onto the operands.
module id_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic       clk,
    input logic       rst,
    id_stage_if.slave bus
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    logic [31:0]     instr;
    logic [6:0]      opcode;
    logic [4:0]      src1;
    logic [4:0]      src2;
    logic [4:0]      rd;
    logic            use_rs1;
    logic            use_rs2;
    logic            legal;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            load_en;
    logic            hazard;

    assign instr   = bus.if_instr;
    assign opcode  = instr[6:0];
    assign src1    = instr[19:15];
    assign src2    = instr[24:20];
    assign bus.rs1 = src1;
    assign bus.rs2 = src2;

    always_comb begin
        imm     = '0;
        legal   = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        rd      = instr[11:7];
        case (opcode)
            OPC_LOAD, OPC_JALR, OPC_OPIMM: begin
                imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
            end
            OPC_STORE: begin
                imm     = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
                use_rs2 = 1'b1;
                rd      = 5'd0;
            end
            OPC_BRANCH: begin
                imm     = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                use_rs2 = 1'b1;
                rd      = 5'd0;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm     = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
                use_rs1 = 1'b0;
            end
            OPC_JAL: begin
                imm     = {{(XLEN-20){instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                use_rs1 = 1'b0;
            end
            OPC_OP: begin
                use_rs2 = 1'b1;
            end
            OPC_MISC, OPC_SYSTEM: begin
                legal = 1'b1;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

`ifdef ID_WB_BYPASS_EN
    // x0 never matches, so a write aimed at x0 cannot leak a nonzero operand.
    assign op_a = (bus.wb_w_enb && bus.wb_rd != 5'd0 && bus.wb_rd == src1) ? bus.wb_w_data : bus.r_data1;
    assign op_b = (bus.wb_w_enb && bus.wb_rd != 5'd0 && bus.wb_rd == src2) ? bus.wb_w_data : bus.r_data2;
`else
    assign op_a = bus.r_data1;
    assign op_b = bus.r_data2;
`endif

    assign load_en = !bus.ex_valid || bus.ex_ready;
    assign hazard  = bus.ex_valid && bus.ex_is_load && (bus.ex_rd != 5'd0) &&
                     ((use_rs1 && src1 == bus.ex_rd) || (use_rs2 && src2 == bus.ex_rd));
    assign bus.if_ready = bus.ex_flush || (load_en && !hazard);

    // Bubbles and flushes only clear ex_valid; stale data fields are ignored downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ex_valid    <= 1'b0;
            bus.ex_pc       <= RESET_PC;
            bus.ex_op_a     <= '0;
            bus.ex_op_b     <= '0;
            bus.ex_imm      <= '0;
            bus.ex_rd       <= '0;
            bus.ex_opcode   <= '0;
            bus.ex_funct3   <= '0;
            bus.ex_funct7b5 <= 1'b0;
            bus.ex_is_load  <= 1'b0;
            bus.ex_illegal  <= 1'b0;
        end else if (bus.ex_flush) begin
            bus.ex_valid <= 1'b0;
        end else if (load_en) begin
            if (hazard || !bus.if_valid) begin
                bus.ex_valid <= 1'b0;
            end else begin
                bus.ex_valid    <= 1'b1;
                bus.ex_pc       <= bus.if_pc;
                bus.ex_op_a     <= op_a;
                bus.ex_op_b     <= op_b;
                bus.ex_imm      <= imm;
                bus.ex_rd       <= rd;
                bus.ex_opcode   <= opcode;
                bus.ex_funct3   <= instr[14:12];
                bus.ex_funct7b5 <= instr[30];
                bus.ex_is_load  <= (opcode == OPC_LOAD);
                bus.ex_illegal  <= !legal;
            end
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Scoreboarded random and directed bench for id_stage against a field-level decode model.
module tb_id_stage;
    localparam logic [31:0] RESET_PC = 32'h0000_0080;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        f7b5;
        logic        is_load;
        logic        illegal;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_stage_if #(.XLEN(32)) bus();
    id_stage #(.XLEN(32), .RESET_PC(RESET_PC)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] regs [32];
    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        q[$];
    exp_t        mon_e;
    logic        m_valid = 1'b0;
    logic        m_load  = 1'b0;
    logic [4:0]  m_rd    = 5'd0;
    bit          pend    = 1'b0;

    assign bus.r_data1 = regs[bus.rs1];
    assign bus.r_data2 = regs[bus.rs2];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'(i) * 32'h1111_1111;
        end else if (bus.wb_w_enb && bus.wb_rd != 5'd0) begin
            regs[bus.wb_rd] <= bus.wb_w_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t decode(input logic [31:0] ins, input logic [31:0] pc, input logic wen,
                                    input logic [4:0] wrd, input logic [31:0] wdat);
        exp_t e;
        byte  kind;
        logic [4:0] r1 = ins[19:15];
        logic [4:0] r2 = ins[24:20];
        case (ins[6:0])
            7'h03, 7'h67, 7'h13: kind = "I";
            7'h23:               kind = "S";
            7'h63:               kind = "B";
            7'h37, 7'h17:        kind = "U";
            7'h6F:               kind = "J";
            default:             kind = "-";
        endcase
        case (kind)
            "I":     e.imm = 32'($signed(ins[31:20]));
            "S":     e.imm = 32'($signed({ins[31:25], ins[11:7]}));
            "B":     e.imm = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
            "U":     e.imm = ins & 32'hFFFF_F000;
            "J":     e.imm = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
            default: e.imm = 32'd0;
        endcase
        e.pc      = pc;
        e.rd      = (kind == "S" || kind == "B") ? 5'd0 : ins[11:7];
        e.opcode  = ins[6:0];
        e.funct3  = ins[14:12];
        e.f7b5    = ins[30];
        e.is_load = (ins[6:0] == 7'h03);
        e.illegal = !(ins[6:0] inside {7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73});
        e.op_a    = regs[r1];
        e.op_b    = regs[r2];
`ifdef ID_WB_BYPASS_EN
        if (wen && wrd != 5'd0 && wrd == r1) e.op_a = wdat;
        if (wen && wrd != 5'd0 && wrd == r2) e.op_b = wdat;
`endif
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] x = $urandom;
        case ($urandom_range(0, 13))
            0, 1, 2: x[6:0] = 7'h03;
            3:       x[6:0] = 7'h0F;
            4:       x[6:0] = 7'h13;
            5:       x[6:0] = 7'h17;
            6:       x[6:0] = 7'h23;
            7, 8:    x[6:0] = 7'h33;
            9:       x[6:0] = 7'h37;
            10:      x[6:0] = 7'h63;
            11:      x[6:0] = 7'h67;
            12:      x[6:0] = 7'h6F;
            default: x[6:0] = ($urandom_range(0, 1) == 0) ? 7'h73 : 7'h5B;
        endcase
        x[11:7]  = 5'($urandom_range(0, 3));
        x[19:15] = 5'($urandom_range(0, 3));
        x[24:20] = 5'($urandom_range(0, 3));
        return x;
    endfunction

    // Scoreboard monitor: whatever sits in ID/EX must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && bus.ex_valid) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL spurious_ex_valid: got ex_valid=1 expected no instruction");
            end else begin
                mon_e = q[0];
                chk("ex_pc", bus.ex_pc, mon_e.pc);
                chk("ex_op_a", bus.ex_op_a, mon_e.op_a);
                chk("ex_op_b", bus.ex_op_b, mon_e.op_b);
                chk("ex_imm", bus.ex_imm, mon_e.imm);
                chk("ex_rd", 32'(bus.ex_rd), 32'(mon_e.rd));
                chk("ex_opcode", 32'(bus.ex_opcode), 32'(mon_e.opcode));
                chk("ex_funct3", 32'(bus.ex_funct3), 32'(mon_e.funct3));
                chk("ex_funct7b5", 32'(bus.ex_funct7b5), 32'(mon_e.f7b5));
                chk("ex_is_load", 32'(bus.ex_is_load), 32'(mon_e.is_load));
                chk("ex_illegal", 32'(bus.ex_illegal), 32'(mon_e.illegal));
                if (bus.ex_ready) void'(q.pop_front());
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic rdy,
                        input logic fl, input logic wen, input logic [4:0] wrd, input logic [31:0] wdat);
        logic u1, u2, le, hz, er;
        exp_t e;
        @(posedge clk);
        #1;
        bus.if_valid  = v;
        bus.if_instr  = ins;
        bus.if_pc     = pc;
        bus.ex_ready  = rdy;
        bus.ex_flush  = fl;
        bus.wb_w_enb  = wen;
        bus.wb_rd     = wrd;
        bus.wb_w_data = wdat;
        @(negedge clk);
        #2;
        u1 = !(ins[6:0] inside {7'h37, 7'h17, 7'h6F});
        u2 = ins[6:0] inside {7'h33, 7'h23, 7'h63};
        le = !m_valid || rdy;
        hz = m_valid && m_load && m_rd != 5'd0 &&
             ((u1 && ins[19:15] == m_rd) || (u2 && ins[24:20] == m_rd));
        er = fl || (le && !hz);
        chk("ex_valid_state", 32'(bus.ex_valid), 32'(m_valid));
        chk("if_ready", 32'(bus.if_ready), 32'(er));
        chk("rs1", 32'(bus.rs1), 32'(ins[19:15]));
        chk("rs2", 32'(bus.rs2), 32'(ins[24:20]));
        if (fl) begin
            q.delete();
            m_valid = 1'b0;
        end else if (le) begin
            if (hz || !v) begin
                m_valid = 1'b0;
            end else begin
                e = decode(ins, pc, wen, wrd, wdat);
                q.push_back(e);
                m_valid = 1'b1;
                m_load  = e.is_load;
                m_rd    = e.rd;
            end
        end
        pend = v && !er;
    endtask

    logic [31:0] ri, rp;
    logic        rv;

    initial begin
        bus.if_valid = 1'b0; bus.if_instr = '0; bus.if_pc = '0; bus.ex_ready = 1'b0;
        bus.ex_flush = 1'b0; bus.wb_w_enb = 1'b0; bus.wb_rd = '0; bus.wb_w_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("reset_ex_pc", bus.ex_pc, RESET_PC);
        chk("reset_ex_imm", bus.ex_imm, 32'd0);
        chk("reset_if_ready", 32'(bus.if_ready), 32'd1);
        rst = 1'b0;

        // sw x2,-4(x1)
        step(1, 32'hFE20AE23, 32'h100, 1, 0, 0, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        chk("store_imm", bus.ex_imm, 32'hFFFF_FFFC);
        chk("store_rd", 32'(bus.ex_rd), 32'd0);
        chk("store_opcode", 32'(bus.ex_opcode), 32'h23);
        chk("store_funct3", 32'(bus.ex_funct3), 32'd2);
        chk("store_op_a", bus.ex_op_a, 32'h1111_1111);
        chk("store_op_b", bus.ex_op_b, 32'h2222_2222);

        // lw x2,0(x1) then add x3,x2,x1
        step(1, 32'h0000A103, 32'h104, 1, 0, 0, 0, 0);
        step(1, 32'h001101B3, 32'h108, 1, 0, 0, 0, 0);
        chk("loaduse_if_ready", 32'(bus.if_ready), 32'd0);
        step(1, 32'h001101B3, 32'h108, 1, 0, 0, 0, 0);
        chk("loaduse_bubble", 32'(bus.ex_valid), 32'd0);
        step(0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        chk("loaduse_add_valid", 32'(bus.ex_valid), 32'd1);
        chk("loaduse_add_rd", 32'(bus.ex_rd), 32'd3);

        // EX stalled for three cycles while fetch offers addi x1,x0,5
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h00500093, 32'h10C, 0, 0, 0, 0, 0);
            chk("stall_if_ready", 32'(bus.if_ready), 32'd0);
            chk("stall_ex_pc", bus.ex_pc, 32'h108);
        end
        step(1, 32'h00500093, 32'h10C, 1, 0, 0, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        chk("stall_capture_pc", bus.ex_pc, 32'h10C);

        step(1, 32'h00700113, 32'h110, 1, 1, 0, 0, 0);
        chk("flush_if_ready", 32'(bus.if_ready), 32'd1);
        step(0, 32'h0, 32'h0, 1, 0, 0, 0, 0);
        chk("flush_ex_valid", 32'(bus.ex_valid), 32'd0);

        // x1 <- 0, then decode add x3,x2,x1 while x1 <- DEADBEEF lands
        step(0, 32'h0, 32'h0, 1, 0, 1, 5'd1, 32'h0);
        step(1, 32'h001101B3, 32'h114, 1, 0, 1, 5'd1, 32'hDEAD_BEEF);
        step(0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
`ifdef ID_WB_BYPASS_EN
        chk("bypass_op_b", bus.ex_op_b, 32'hDEAD_BEEF);
`else
        chk("bypass_op_b", bus.ex_op_b, 32'h0);
`endif

        for (int i = 0; i < 3000; i++) begin
            if (!pend) begin
                rv = ($urandom_range(0, 9) < 8);
                ri = rand_instr();
                rp = $urandom & 32'hFFFF_FFFC;
            end
            step(rv, ri, rp, ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
        end

        // Reset while an instruction is held in ID/EX
        step(0, 32'h0, 32'h0, 1, 0, 0, 0, 0);
        step(1, 32'h00100093, 32'h200, 1, 0, 0, 0, 0);
        step(0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
        chk("midreset_pre_valid", 32'(bus.ex_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("midreset_ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("midreset_ex_pc", bus.ex_pc, RESET_PC);
        chk("midreset_ex_op_a", bus.ex_op_a, 32'd0);
        q.delete();
        m_valid = 1'b0;
        pend    = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 300; i++) begin
            if (!pend) begin
                rv = ($urandom_range(0, 9) < 8);
                ri = rand_instr();
                rp = $urandom & 32'hFFFF_FFFC;
            end
            step(rv, ri, rp, ($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom);
        end
        repeat (3) step(0, 32'h0, 32'h0, 1, 0, 0, 0, 0);
        chk("drain_queue_empty", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
